// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
//   PS/2 keyboard receiver running in the system clock domain. Both PS/2
//   lines are synchronised and oversampled. ps2_clk is deglitched, and
//   11-bit frames (start, 8 data LSB-first, odd parity, stop) are decoded.
//   E0/F0 prefix bytes are folded into tags on the next scan code. Tagged
//   events are queued in a first-word-fall-through FIFO.
//
// Parameters
//   FILTER_LEN   consecutive equal samples before the filtered clock moves
//   TIMEOUT_CYC  max clk cycles between falling edges inside a frame
//   FIFO_DEPTH   event FIFO entries (power of 2, >= 2)
//
// Ports
//   clk, rst        system clock, asynchronous active-low reset
//   ps2_clk/data    raw PS/2 lines (asynchronous)
//   rd_en           pop FIFO head (ignored while valid=0)
//   clr_ovf         clear sticky overflow
//   valid           FIFO holds at least one event
//   code            head scan code
//   is_break        head event was preceded by F0
//   is_ext          head event was preceded by E0
//   fifo_count      entries held, 0..FIFO_DEPTH
//   bsy             frame reception in progress
//   parity_err      1-cycle pulse, bad parity
//   frame_err       1-cycle pulse, stop bit low
//   timeout_err     1-cycle pulse, frame aborted by inter-bit timeout
//   overflow        sticky, an event was dropped on a full FIFO
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          clr_ovf,
    output logic                          valid,
    output logic [7:0]                    code,
    output logic                          is_break,
    output logic                          is_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          bsy,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          timeout_err,
    output logic                          overflow
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------------
    // Synchronisers reset to the idle-high line level so that releasing reset
    // never looks like a falling clock edge.
    logic clk_s1, clk_s2, dat_s1, dat_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock follows the synced clock only after FILTER_LEN
    // consecutive samples that differ from it. Any sample equal to the
    // current level restarts the count, so short glitches are absorbed.
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          strobe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
                strobe   <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    state_t        state, state_n;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          stop_bit;
    logic          chk_pend;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n     = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:   if (strobe && !dat_s2)           state_n = S_DATA;
            S_DATA:   if (strobe && bit_cnt == 3'd7)   state_n = S_PARITY;
            S_PARITY: if (strobe)                      state_n = S_STOP;
            S_STOP:   if (strobe)                      state_n = S_IDLE;
            default:                                   state_n = S_IDLE;
        endcase
        // A strobe restarts the inter-bit timer, so it always wins over a timeout.
        if (state != S_IDLE && !strobe && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state_n     = S_IDLE;
            timeout_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bit <= 1'b0;
            chk_pend <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            chk_pend <= 1'b0;
            if (state == S_IDLE || strobe) tmo_cnt <= '0;
            else                           tmo_cnt <= tmo_cnt + 1'b1;
            if (strobe) begin
                case (state)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shreg[bit_cnt] <= dat_s2;
                        bit_cnt        <= bit_cnt + 1'b1;
                    end
                    S_PARITY: par_bit <= dat_s2;
                    S_STOP: begin
                        stop_bit <= dat_s2;
                        chk_pend <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bsy = (state != S_IDLE);

    // ---------------------------------------------------------------------
    // Frame check and prefix folding (cycle after the stop strobe)
    // ---------------------------------------------------------------------
    logic       par_bad, frm_bad, frm_good, push;
    logic       ext_pend, brk_pend;
    logic [9:0] push_word;

    always_comb begin
        par_bad   = chk_pend && (^{shreg, par_bit} != 1'b1);
        frm_bad   = chk_pend && !par_bad && !stop_bit;
        frm_good  = chk_pend && !par_bad && stop_bit;
        push      = frm_good && shreg != CODE_EXT && shreg != CODE_BRK;
        push_word = {ext_pend, brk_pend, shreg};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            parity_err  <= par_bad;
            frame_err   <= frm_bad;
            timeout_err <= timeout_hit;
            if (par_bad || frm_bad || timeout_hit) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (frm_good) begin
                if (shreg == CODE_EXT) begin
                    ext_pend <= 1'b1;
                end else if (shreg == CODE_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Event FIFO, first-word-fall-through with registered head
    // ---------------------------------------------------------------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0] cnt_n;
    logic          pop, full, wr_ok, drop;
    logic [9:0]    head_n;

    always_comb begin
        pop      = rd_en && valid;
        full     = (fifo_count == CW'(FIFO_DEPTH));
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        wr_ok    = push && (!full || pop);
        drop     = push && full && !pop;
        cnt_n    = fifo_count + CW'(wr_ok) - CW'(pop);
        rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
        // The head register is loaded with what the head will be after this
        // edge. If the FIFO drains to nothing but the pushed word, that word
        // bypasses the memory because it is only written on this same edge.
        if (cnt_n == '0)
            head_n = '0;
        else if (wr_ok && (fifo_count - CW'(pop)) == '0)
            head_n = push_word;
        else
            head_n = mem[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            valid      <= 1'b0;
            code       <= '0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= rd_ptr_n;
            fifo_count <= cnt_n;
            valid      <= (cnt_n != '0);
            {is_ext, is_break, code} <= head_n;
            // A new drop outranks a simultaneous clear.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;
    localparam int FL    = 8;
    localparam int TO    = 300;
    localparam int DEPTH = 8;
    localparam int HALF  = 20;   // clk cycles per PS/2 clock half period

    logic       clk = 1'b0, rst = 1'b0;
    logic       ps2_clk = 1'b1, ps2_data = 1'b1;
    logic       rd_en = 1'b0, clr_ovf = 1'b0;
    logic       valid, is_break, is_ext, bsy;
    logic [7:0] code;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       parity_err, frame_err, timeout_err, overflow;

    always #10 clk = ~clk;

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .valid(valid), .code(code),
        .is_break(is_break), .is_ext(is_ext), .fifo_count(fifo_count),
        .bsy(bsy), .parity_err(parity_err), .frame_err(frame_err),
        .timeout_err(timeout_err), .overflow(overflow)
    );

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    ev_t  exp_q[$];
    byte  err_q[$];
    bit   m_ext = 1'b0, m_brk = 1'b0, exp_ovf = 1'b0;
    int   rd_prob = 0;
    int   checks = 0, errors = 0;
    ev_t  mon_e;
    byte  got_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: what one complete frame means at the event level.
    task automatic model_frame(input logic [7:0] c, input bit pgood, input bit stop_v);
        if (!pgood) begin
            err_q.push_back("P"); m_ext = 0; m_brk = 0;
        end else if (!stop_v) begin
            err_q.push_back("F"); m_ext = 0; m_brk = 0;
        end else if (c == 8'hE0) begin
            m_ext = 1;
        end else if (c == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back('{ext: m_ext, brk: m_brk, code: c});
            else                      exp_ovf = 1;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit pgood, input bit stop_v);
        logic [10:0] bits;
        bits = {stop_v, (~^c) ^ ~pgood, c, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == 10) model_frame(c, pgood, stop_v);
            ps2_bit(bits[i]);
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_partial(input int n, input logic [7:0] c);
        logic [8:0] bits;
        bits = {c, 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
    endtask

    task automatic drain();
        rd_prob = 100;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
        chk("drain_count", fifo_count, 0);
        rd_prob = 0;
    endtask

    // Event monitor: pops the DUT when it presents data, compares with the model.
    initial begin
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (rst && valid && int'($urandom_range(99)) < rd_prob) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL event_unexpected actual=%0h required=none", {is_ext, is_break, code});
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event", {is_ext, is_break, code}, mon_e);
                end
                rd_en = 1'b1;
            end
        end
    end

    // Error pulse monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && (parity_err || frame_err || timeout_err)) begin
                got_err = parity_err ? "P" : frame_err ? "F" : "T";
                if (err_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL err_unexpected actual=%s required=none", got_err);
                end else begin
                    chk("err_pulse", got_err, err_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    logic [7:0] rc;
    bit         rpg, rsv, saw;

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_outs", {valid, code, is_break, is_ext, fifo_count, bsy,
                           parity_err, frame_err, timeout_err, overflow}, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Single plain frame
        send_frame(8'h15, 1, 1);
        chk("t1_valid", valid, 1);
        chk("t1_head", {is_ext, is_break, code}, 10'h015);
        chk("t1_count", fifo_count, 1);
        chk("t1_bsy", bsy, 0);
        drain();

        // Prefix folding
        send_frame(8'hF0, 1, 1); send_frame(8'h15, 1, 1);
        send_frame(8'hE0, 1, 1); send_frame(8'hF0, 1, 1); send_frame(8'h75, 1, 1);
        chk("t2_count", fifo_count, 2);
        chk("t2_head", {is_ext, is_break, code}, 10'h115);
        drain();

        // Parity and framing errors, each clearing a pending prefix
        send_frame(8'hF0, 1, 1);
        send_frame(8'h15, 0, 1);
        chk("t3_count_par", fifo_count, 0);
        send_frame(8'hF0, 1, 1);
        send_frame(8'h15, 1, 0);
        chk("t3_count_frm", fifo_count, 0);
        send_frame(8'h15, 1, 1);
        drain();

        // Timeout mid-frame, also drops the pending E0
        send_frame(8'hE0, 1, 1);
        err_q.push_back("T"); m_ext = 0; m_brk = 0;
        send_partial(5, 8'h6B);
        repeat (TO + 4 * HALF) @(negedge clk);
        chk("t4_bsy", bsy, 0);
        send_frame(8'h1C, 1, 1);
        drain();

        // Short low glitch on ps2_clk in idle
        saw = 0;
        @(negedge clk); ps2_data = 1'b0; ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        for (int i = 0; i < 40; i++) begin @(negedge clk); saw |= bsy; end
        ps2_data = 1'b1;
        chk("t5_glitch_bsy", saw, 0);

        // Reset in the middle of a frame with an event queued
        send_frame(8'h33, 1, 1);
        chk("t5_pre_count", fifo_count, 1);
        send_partial(4, 8'h5A);
        chk("t5_mid_bsy", bsy, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_rst_outs", {valid, code, is_break, is_ext, fifo_count, bsy,
                            parity_err, frame_err, timeout_err, overflow}, 0);
        exp_q.delete(); err_q.delete(); m_ext = 0; m_brk = 0; exp_ovf = 0;
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Overflow
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1, 1);
        chk("t6_count", fifo_count, DEPTH);
        chk("t6_ovf", overflow, exp_ovf);
        chk("t6_head", code, 8'h01);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0; exp_ovf = 0;
        chk("t6_clr", overflow, 0);
        drain();

        // Random traffic with a concurrent reader
        rd_prob = 50;
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(9))
                0:       rc = 8'hE0;
                1:       rc = 8'hF0;
                default: rc = 8'($urandom);
            endcase
            rpg = ($urandom_range(9) != 0);
            rsv = ($urandom_range(9) != 0);
            send_frame(rc, rpg, rsv);
        end
        drain();
        chk("err_left", err_q.size(), 0);
        chk("ovf_final", overflow, exp_ovf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
